// File: rtl/reg_file_param_pkg.sv
// Shared constants for the parameterised register file.
//   RF_ST_*   : init-sweep FSM state encodings
//   RF_INIT_* : values accepted by the INIT_MODE parameter
package reg_file_param_pkg;

  localparam logic [0:0] RF_ST_INIT = 1'b0;
  localparam logic [0:0] RF_ST_RUN  = 1'b1;

  localparam int RF_INIT_ZERO  = 0;
  localparam int RF_INIT_INDEX = 1;

endpackage

// File: rtl/reg_file_param_if.sv
// Bus between the decode stage and the register file.
//   write/WR/WD/WBE : write port (byte enables, WBE[i] covers WD[8i+7:8i])
//   PR              : packed read addresses, port k = PR[k*ADDR_W +: ADDR_W]
//   RD              : packed read data,      port k = RD[k*DATA_W +: DATA_W]
//   ready           : file initialised; writes are ignored while low
// master = decode stage side, slave = register file side.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       write;
  logic [ADDR_W-1:0]          WR;
  logic [DATA_W-1:0]          WD;
  logic [DATA_W/8-1:0]        WBE;
  logic [NUM_RD*ADDR_W-1:0]   PR;
  logic [NUM_RD*DATA_W-1:0]   RD;
  logic                       ready;

  modport master (output write, WR, WD, WBE, PR, input RD, ready);
  modport slave  (input write, WR, WD, WBE, PR, output RD, ready);
endinterface

// File: rtl/reg_file_init_fsm.sv
// Post-reset init sweep controller for the register file.
//   clk, rst      : clock, synchronous active-high reset
//   o_init_we     : sweep is writing the init value this cycle
//   o_init_addr   : register being initialised
//   o_ready       : sweep finished, file usable
//
//   state | meaning
//   ------+----------------------------------------------------------
//   INIT  | writing one register per edge, pointer walks 0..DEPTH-1
//   RUN   | sweep done, ready high until the next reset
module reg_file_init_fsm
  import reg_file_param_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_ready
);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_ST_INIT;
      r_ptr   <= '0;
    end else if (r_state == RF_ST_INIT) begin
      // Last register written this edge: leave INIT without bumping the
      // pointer so it never wraps back to 0.
      if (r_ptr == {ADDR_W{1'b1}}) begin
        r_state <= RF_ST_RUN;
      end else begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
    end
  end

  // A reset edge must not also perform a sweep write.
  assign o_init_we   = (r_state == RF_ST_INIT) && !rst;
  assign o_init_addr = r_ptr;
  assign o_ready     = (r_state == RF_ST_RUN);

endmodule

// File: rtl/reg_file_param.sv
// Parameterised register file: NUM_RD combinational read ports, one
// byte-enabled write port with optional write-through bypass, optional
// hardwired-zero register 0, and a post-reset init sweep.
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_file_param_if slave (write/WR/WD/WBE/PR in, RD/ready out)
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  reg_file_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_ready;
  logic [DATA_W-1:0] w_init_val;
  logic              w_port_we;
  logic [DATA_W-1:0] w_merged;

  reg_file_init_fsm #(.ADDR_W(ADDR_W)) u_init_fsm (
    .clk         (clk),
    .rst         (rst),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_ready     (w_ready)
  );

  assign w_init_val = (INIT_MODE == RF_INIT_INDEX) ? DATA_W'(w_init_addr) : '0;

  // Port write is live only once ready, and never targets a hardwired reg 0.
  assign w_port_we = w_ready && bus.write &&
                     !((ZERO_REG != 0) && (bus.WR == '0));

  // Post-write value of mem[WR]; feeds both the array and the bypass path.
  always_comb begin
    w_merged = r_mem[bus.WR];
    for (int i = 0; i < NB; i++) begin
      if (bus.WBE[i]) w_merged[8*i +: 8] = bus.WD[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init_we) begin
        r_mem[w_init_addr] <= w_init_val;
      end else if (w_port_we) begin
        r_mem[bus.WR] <= w_merged;
      end
    end
  end

  assign bus.ready = w_ready;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = bus.PR[k*ADDR_W +: ADDR_W];

    always_comb begin
      if (!w_ready) begin
        w_data = '0;
      end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
      end else if ((BYPASS != 0) && w_port_we && (w_addr == bus.WR)) begin
        w_data = w_merged;
      end else begin
        w_data = r_mem[w_addr];
      end
    end

    assign bus.RD[k*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_reg_file_param.sv
`timescale 1ns/1ps
module tb_reg_file_param;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: defaults. dut1: 64-bit, 3 ports, no zero reg, no bypass. dut2: 1 port, zero init.
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if0 ();
  reg_file_param_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3)) if1 ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1)) if2 ();

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  reg_file_param #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0), .INIT_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic        t_write [ND];
  logic [4:0]  t_wr    [ND];
  logic [63:0] t_wd    [ND];
  logic [7:0]  t_wbe   [ND];
  logic [4:0]  t_pr    [ND][3];
  logic [63:0] o_rd    [ND][3];
  logic        o_ready [ND];

  assign if0.write = t_write[0];
  assign if0.WR    = t_wr[0];
  assign if0.WD    = t_wd[0][31:0];
  assign if0.WBE   = t_wbe[0][3:0];
  assign if0.PR    = {t_pr[0][1], t_pr[0][0]};
  assign if1.write = t_write[1];
  assign if1.WR    = t_wr[1];
  assign if1.WD    = t_wd[1];
  assign if1.WBE   = t_wbe[1];
  assign if1.PR    = {t_pr[1][2], t_pr[1][1], t_pr[1][0]};
  assign if2.write = t_write[2];
  assign if2.WR    = t_wr[2];
  assign if2.WD    = t_wd[2][31:0];
  assign if2.WBE   = t_wbe[2][3:0];
  assign if2.PR    = t_pr[2][0];

  assign o_rd[0][0] = {32'b0, if0.RD[31:0]};
  assign o_rd[0][1] = {32'b0, if0.RD[63:32]};
  assign o_rd[0][2] = '0;
  assign o_rd[1][0] = if1.RD[63:0];
  assign o_rd[1][1] = if1.RD[127:64];
  assign o_rd[1][2] = if1.RD[191:128];
  assign o_rd[2][0] = {32'b0, if2.RD};
  assign o_rd[2][1] = '0;
  assign o_rd[2][2] = '0;
  assign o_ready[0] = if0.ready;
  assign o_ready[1] = if1.ready;
  assign o_ready[2] = if2.ready;

  function automatic int cfg_dw(int d);   return (d == 1) ? 64 : 32; endfunction
  function automatic int cfg_nrd(int d);  return (d == 0) ? 2 : (d == 1) ? 3 : 1; endfunction
  function automatic bit cfg_zero(int d); return d != 1; endfunction
  function automatic bit cfg_byp(int d);  return d != 1; endfunction
  function automatic bit cfg_idx(int d);  return d != 2; endfunction

  // Reference model: plain array per DUT plus a count of sweep edges.
  logic [63:0] m_mem   [ND][32];
  bit          m_ready [ND];
  int          m_cnt   [ND];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  function automatic logic [63:0] merged(int d);
    logic [63:0] r;
    r = m_mem[d][t_wr[d]];
    for (int b = 0; b < cfg_dw(d) / 8; b++)
      if (t_wbe[d][b]) r[8*b +: 8] = t_wd[d][8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_rd(int d, int k);
    logic [4:0] a;
    a = t_pr[d][k];
    if (!m_ready[d]) return 64'd0;
    if (cfg_zero(d) && a == 5'd0) return 64'd0;
    if (cfg_byp(d) && t_write[d] && a == t_wr[d] && !(cfg_zero(d) && t_wr[d] == 5'd0))
      return merged(d);
    return m_mem[d][a];
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_ready[d] = 0;
        m_cnt[d]   = 0;
      end else if (!m_ready[d]) begin
        m_mem[d][m_cnt[d]] = cfg_idx(d) ? 64'(m_cnt[d]) : 64'd0;
        m_cnt[d]++;
        if (m_cnt[d] == 32) m_ready[d] = 1;
      end else if (t_write[d] && !(cfg_zero(d) && t_wr[d] == 5'd0)) begin
        m_mem[d][t_wr[d]] = merged(d);
      end
    end
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("ready d%0d", d), 64'(o_ready[d]), 64'(m_ready[d]));
        for (int k = 0; k < cfg_nrd(d); k++)
          check($sformatf("rd d%0d p%0d a%0d", d, k, t_pr[d][k]), o_rd[d][k], exp_rd(d, k));
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_inputs(bit force_write);
    for (int d = 0; d < ND; d++) begin
      t_write[d] = force_write ? 1'b1 : 1'($urandom_range(0, 1));
      t_wr[d]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      t_wd[d]    = {$urandom, $urandom};
      t_wbe[d]   = 8'($urandom);
      for (int k = 0; k < 3; k++)
        t_pr[d][k] = ($urandom_range(0, 2) == 0) ? t_wr[d] : 5'($urandom);
    end
  endtask

  typedef struct {
    int          d;
    int          k;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [7:0]  wbe;
    logic [4:0]  pr;
    logic [63:0] exp_during;
    logic [63:0] exp_after;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    vecs[0] = '{0, 0, 5'd4,  64'd31,                  8'h0F, 5'd4,  64'd31,                  64'd31};
    vecs[1] = '{0, 0, 5'd9,  64'hAABBCCDD,            8'h05, 5'd9,  64'h00BB00DD,            64'h00BB00DD};
    vecs[2] = '{0, 1, 5'd0,  64'd55,                  8'h0F, 5'd0,  64'd0,                   64'd0};
    vecs[3] = '{0, 1, 5'd7,  64'h12345678,            8'h00, 5'd7,  64'd7,                   64'd7};
    vecs[4] = '{0, 0, 5'd10, 64'hFFFFFFFF,            8'h08, 5'd10, 64'hFF00000A,            64'hFF00000A};
    vecs[5] = '{1, 1, 5'd12, 64'd7,                   8'hFF, 5'd12, 64'd12,                  64'd7};
    vecs[6] = '{1, 0, 5'd0,  64'd55,                  8'hFF, 5'd0,  64'd0,                   64'd55};
    vecs[7] = '{1, 2, 5'd3,  64'h1122334455667788,    8'hF0, 5'd3,  64'd3,                   64'h1122334400000003};
    vecs[8] = '{2, 0, 5'd5,  64'hDEADBEEF,            8'h03, 5'd5,  64'h0000BEEF,            64'h0000BEEF};

    for (int d = 0; d < ND; d++) begin
      t_write[d] = 0; t_wr[d] = '0; t_wd[d] = '0; t_wbe[d] = '0;
      for (int k = 0; k < 3; k++) t_pr[d][k] = '0;
      m_ready[d] = 0; m_cnt[d] = 0;
    end

    // Reset for two edges, then count edges until ready.
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    chk_en = 1;
    rst = 1'b0;
    n = 0;
    while (!o_ready[0] && n < 100) begin
      cycle();
      n++;
    end
    check("ready_latency", 64'(n), 64'd32);

    t_pr[0][0] = 5'd6;
    t_pr[0][1] = 5'd8;
    #1;
    check("init_rd0", o_rd[0][0], 64'd6);
    check("init_rd1", o_rd[0][1], 64'd8);

    // Directed write vectors: value seen during the write cycle and after the edge.
    for (int i = 0; i < 9; i++) begin
      t_write[vecs[i].d]           = 1'b1;
      t_wr[vecs[i].d]              = vecs[i].wr;
      t_wd[vecs[i].d]              = vecs[i].wd;
      t_wbe[vecs[i].d]             = vecs[i].wbe;
      t_pr[vecs[i].d][vecs[i].k]   = vecs[i].pr;
      #1;
      check($sformatf("vec%0d during", i), o_rd[vecs[i].d][vecs[i].k], vecs[i].exp_during);
      cycle();
      t_write[vecs[i].d] = 1'b0;
      #1;
      check($sformatf("vec%0d after", i), o_rd[vecs[i].d][vecs[i].k], vecs[i].exp_after);
    end

    for (int i = 0; i < 200; i++) begin
      rand_inputs(0);
      cycle();
    end

    // One-cycle reset in RUN with writes pending, then writes hammering the sweep.
    rand_inputs(1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rand_inputs(1);
      cycle();
      if (i == 30) check("not_ready_31", 64'(o_ready[0]), 64'd0);
    end
    check("ready_after_sweep", 64'(o_ready[0]), 64'd1);
    for (int d = 0; d < ND; d++) t_write[d] = 1'b0;
    for (int a = 0; a < 32; a++) begin
      for (int d = 0; d < ND; d++) t_pr[d][0] = 5'(a);
      #1;
      check($sformatf("sweep d0 a%0d", a), o_rd[0][0], (a == 0) ? 64'd0 : 64'(a));
      check($sformatf("sweep d1 a%0d", a), o_rd[1][0], 64'(a));
      check($sformatf("sweep d2 a%0d", a), o_rd[2][0], 64'd0);
      cycle();
    end

    for (int i = 0; i < 300; i++) begin
      rand_inputs(0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
